except_ctrl: RTL

// - Exception arbiter/issuer at the MEM stage; the producing end of the CP0 exception interface.
// - Merges MEM-stage exception flags with pending interrupts, using CP0 Status/Cause/EPC forwarded from the WB write port.
// - Issues a one-cycle excepttype pulse plus the faulting PC and delay-slot flag to CP0.
// - Drives the pipeline flush and the redirect PC.

---
 rtl/except_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/except_ctrl.sv
// MEM-stage exception arbiter: it merges exception flags with pending interrupts and issues a
// one-cycle exception code to CP0, then holds the pipeline flush and the redirect PC.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_inst_addr_i,
  input  logic        mem_in_delayslot_i,
  input  logic [4:0]  mem_except_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [4:0]  REG_STATUS = 5'd12;
  localparam logic [4:0]  REG_CAUSE  = 5'd13;
  localparam logic [4:0]  REG_EPC    = 5'd14;
  localparam logic [3:0]  CNT_INIT   = 4'(FLUSH_CYCLES - 1);

  localparam logic [31:0] CODE_INT  = 32'h0000_0001;
  localparam logic [31:0] CODE_SYS  = 32'h0000_0008;
  localparam logic [31:0] CODE_RI   = 32'h0000_000a;
  localparam logic [31:0] CODE_TRAP = 32'h0000_000d;
  localparam logic [31:0] CODE_OV   = 32'h0000_000c;
  localparam logic [31:0] CODE_ERET = 32'h0000_000e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] excepttype_q;
  logic [31:0] inst_addr_q;
  logic        delayslot_q;
  logic        flush_q;
  logic [31:0] new_pc_q;
  logic        busy_q;

  logic [31:0] status_eff;
  logic [31:0] cause_eff;
  logic [31:0] epc_eff;
  logic        int_pending;
  logic        detect;
  logic [31:0] code_d;
  logic [31:0] new_pc_d;

  // An mtc0 in WB lands in CP0 only after this cycle, so its value is forwarded here.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      unique case (wb_cp0_waddr_i)
        REG_STATUS: status_eff = wb_cp0_data_i;
        REG_CAUSE: begin
          cause_eff[9:8]   = wb_cp0_data_i[9:8];
          cause_eff[23:22] = wb_cp0_data_i[23:22];
        end
        REG_EPC:    epc_eff = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

  assign int_pending = (|(cause_eff[15:8] & status_eff[15:8]))
                       && status_eff[0] && !status_eff[1];

  assign detect = (state_q == IDLE) && mem_valid_i && !stall_i
                  && (int_pending || (|mem_except_i));

  always_comb begin
    code_d = 32'h0;
    if (int_pending)          code_d = CODE_INT;
    else if (mem_except_i[0]) code_d = CODE_SYS;
    else if (mem_except_i[1]) code_d = CODE_RI;
    else if (mem_except_i[2]) code_d = CODE_TRAP;
    else if (mem_except_i[3]) code_d = CODE_OV;
    else if (mem_except_i[4]) code_d = CODE_ERET;
  end

  assign new_pc_d = (code_d == CODE_ERET) ? epc_eff : EXC_VECTOR;

  // Status/Cause bits outside the interrupt fields play no part in arbitration.
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{status_eff[31:16], status_eff[7:2],
                             cause_eff[31:16], cause_eff[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      excepttype_q <= 32'h0;
      inst_addr_q  <= 32'h0;
      delayslot_q  <= 1'b0;
      flush_q      <= 1'b0;
      new_pc_q     <= 32'h0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      unique case (state_q)
        IDLE: begin
          if (detect) begin
            excepttype_q <= code_d;
            inst_addr_q  <= mem_inst_addr_i;
            delayslot_q  <= mem_in_delayslot_i;
            flush_q      <= 1'b1;
            busy_q       <= 1'b1;
            new_pc_q     <= new_pc_d;
            cnt_q        <= CNT_INIT;
            state_q      <= FLUSH;
          end else begin
            excepttype_q <= 32'h0;
            flush_q      <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        FLUSH: begin
          excepttype_q <= 32'h0;
          if (cnt_q == 4'd0) begin
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  assign excepttype_o        = excepttype_q;
  assign current_inst_addr_o = inst_addr_q;
  assign is_in_delayslot_o   = delayslot_q;
  assign flush_o             = flush_q;
  assign new_pc_o            = new_pc_q;
  assign busy_o              = busy_q;

endmodule
